score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter NUM_DIGITS, default 5: number of BCD score digits, legal range 3..8.
REQ-002 Parameter TICK_DIV, default 1: qualified game ticks per score increment, legal range 1..15.
REQ-003 Parameter LEVEL_W, default 3: width of the level counter.
REQ-004 Port clk  input  1: single clock; all logic is rising-edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port game_start  input  1: one-cycle pulse that starts a new run.
REQ-007 Port game_over  input  1: one-cycle pulse that ends the current run.
REQ-008 Port game_frozen  input  1: level signal; while high, game ticks are ignored.
REQ-009 Port game_tick  input  1: one-cycle pulse at the 20 Hz game rate.
REQ-010 Port score  output  4*NUM_DIGITS: current score, packed BCD, digit 0 in bits [3:0].
REQ-011 Port high_score  output  4*NUM_DIGITS: best score since reset, packed BCD.
REQ-012 Port level  output  LEVEL_W: speed level, incremented every 100 points.
REQ-013 Port milestone  output  1: one-cycle pulse on each 100-point crossing, used to drive audio.
REQ-014 Port new_high  output  1: one-cycle pulse when high_score is replaced.

Function
REQ-015 A qualified tick SHALL be game_tick=1 with game_frozen=0 and game_start=0.
REQ-016 A divider counter of 4 bits SHALL count qualified ticks from 0 to TICK_DIV-1 and then wrap to 0; the wrap event SHALL be the increment strobe.
REQ-017 On the increment strobe, score SHALL increase by 1 in BCD with ripple carry; the new value SHALL be visible on the cycle after the tick.
REQ-018 A digit value above 9 SHALL never appear on score or high_score.
REQ-019 When all digits are 9, score SHALL hold its value: no wrap and no milestone.
REQ-020 milestone SHALL pulse on the cycle score is updated, when the incremented score has digits 1 and 0 both equal to 0.
REQ-021 level SHALL increment on each milestone and SHALL saturate at 2^LEVEL_W-1.
REQ-022 On game_start, score, level and the divider SHALL clear to 0 on the next cycle; game_start SHALL override a tick in the same cycle.
REQ-023 On game_over, if score > high_score (unsigned BCD compare), high_score SHALL load score and new_high SHALL pulse on the next cycle; if score is equal or lower, there SHALL be no change.
REQ-024 When game_over and game_start arrive in the same cycle, the compare SHALL use the pre-clear score, and score SHALL still clear.
REQ-025 When game_over and the increment strobe arrive in the same cycle, the compare SHALL use the pre-increment score, and the increment SHALL still occur.
REQ-026 While game_frozen is high, the divider SHALL hold and score and level SHALL hold.
REQ-027 milestone and new_high SHALL be registered and SHALL never stay high for 2 consecutive cycles.

Reset
REQ-028 While rst is high, score, high_score, level, divider, milestone and new_high SHALL be 0 at the next clock edge.
REQ-029 rst SHALL take priority over all other inputs, including in the middle of a carry or a compare.

Configuration
REQ-030 Macro SCORE_KEEPER_HIGH_SCORE_EN: when defined, the high-score register, the compare and new_high SHALL be implemented as in REQ-023..025.
REQ-031 When SCORE_KEEPER_HIGH_SCORE_EN is undefined, high_score and new_high SHALL be tied to 0, no compare logic SHALL be present, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Reset, then game_start, then 3 ticks with TICK_DIV=1 -> score=0x00003, level=0, milestone never high.
REQ-033 Preload score 0x00099, then 1 tick -> score=0x00100, milestone pulses for exactly one cycle, level=1.
REQ-034 Preload score 0x99999, then 5 ticks -> score stays 0x99999, no milestone.
REQ-035 TICK_DIV=3, 7 ticks with game_frozen high during ticks 4 and 5 -> score=0x00001 and divider=2.
REQ-036 With the macro defined: score 0x00042 with game_over -> high_score=0x00042 and new_high pulses; then game_start, score 0x00017, game_over -> high_score stays 0x00042 and no new_high.
REQ-037 game_over and game_start in the same cycle at score 0x00050 -> high_score=0x00050 and score=0 on the next cycle.

Source files
------------

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//   Game score keeper. Qualified game ticks are divided down by TICK_DIV and
//   each divider wrap adds one point to a packed-BCD score (ripple carry,
//   saturating at all nines). Every 100-point crossing pulses milestone and
//   bumps a saturating speed level. An optional high-score register captures
//   the score at game_over when it beats the stored best.
//
//   Optional feature macro: SCORE_KEEPER_HIGH_SCORE_EN
//     defined   -> high_score register, compare and new_high pulse present
//     undefined -> high_score and new_high tied to 0, no compare logic
//
// Parameters
//   NUM_DIGITS  number of BCD score digits (3..8)
//   TICK_DIV    qualified ticks per score increment (1..15)
//   LEVEL_W     width of the level counter
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   game_start   in   one-cycle pulse, starts a new run (clears score/level/divider)
//   game_over    in   one-cycle pulse, ends the run (high-score compare)
//   game_frozen  in   level; while high, game ticks are ignored
//   game_tick    in   one-cycle pulse at the game rate
//   score        out  current score, packed BCD, digit 0 in [3:0]
//   high_score   out  best score since reset, packed BCD
//   level        out  speed level, +1 per 100 points, saturating
//   milestone    out  one-cycle pulse on each 100-point crossing
//   new_high     out  one-cycle pulse when high_score is replaced
// -----------------------------------------------------------------------------
module score_keeper #(
  parameter int NUM_DIGITS = 5,
  parameter int TICK_DIV   = 1,
  parameter int LEVEL_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    game_start,
  input  logic                    game_over,
  input  logic                    game_frozen,
  input  logic                    game_tick,
  output logic [4*NUM_DIGITS-1:0] score,
  output logic [4*NUM_DIGITS-1:0] high_score,
  output logic [LEVEL_W-1:0]      level,
  output logic                    milestone,
  output logic                    new_high
);

  localparam int SW = 4 * NUM_DIGITS;

  logic [3:0]    div_cnt;
  logic          qual_tick;
  logic          div_wrap;
  logic [SW-1:0] score_inc;
  logic          all_nine;
  logic          carry;

  // game_start wins over a tick in the same cycle; frozen suppresses ticks.
  assign qual_tick = game_tick & ~game_frozen & ~game_start;
  assign div_wrap  = qual_tick && (div_cnt == 4'(TICK_DIV - 1));

  // Ripple-carry BCD +1. A nine rolls to zero and passes the carry on; the
  // first digit below nine absorbs it. all_nine flags the saturated score.
  always_comb begin
    score_inc = score;
    carry     = 1'b1;
    all_nine  = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (score[4*d +: 4] != 4'd9) all_nine = 1'b0;
      if (carry) begin
        if (score[4*d +: 4] == 4'd9) begin
          score_inc[4*d +: 4] = 4'd0;
        end else begin
          score_inc[4*d +: 4] = score[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Score, level, divider and milestone.
  always_ff @(posedge clk) begin
    if (rst) begin
      score     <= '0;
      level     <= '0;
      div_cnt   <= 4'd0;
      milestone <= 1'b0;
    end else begin
      milestone <= 1'b0;
      if (game_start) begin
        score   <= '0;
        level   <= '0;
        div_cnt <= 4'd0;
      end else if (qual_tick) begin
        if (div_wrap) begin
          div_cnt <= 4'd0;
          // At all nines the score holds: no wrap and no milestone.
          if (!all_nine) begin
            score <= score_inc;
            if (score_inc[7:0] == 8'h00) begin
              milestone <= 1'b1;
              if (level != {LEVEL_W{1'b1}}) level <= level + LEVEL_W'(1);
            end
          end
        end else begin
          div_cnt <= div_cnt + 4'd1;
        end
      end
    end
  end

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  // With every digit held in 0..9, a plain unsigned compare of the packed
  // vectors orders BCD values correctly. The compare sees the registered
  // score, i.e. the value before any same-cycle clear or increment.
  // new_high is forced low on the cycle after a pulse so back-to-back
  // game_over pulses cannot hold it high for two cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      high_score <= '0;
      new_high   <= 1'b0;
    end else begin
      new_high <= 1'b0;
      if (game_over && (score > high_score)) begin
        high_score <= score;
        new_high   <= ~new_high;
      end
    end
  end
`else
  logic unused_game_over;
  assign unused_game_over = game_over;
  assign high_score       = '0;
  assign new_high         = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
//   Three score_keeper instances share one stimulus stream:
//     u_main : defaults (5 digits, TICK_DIV=1)
//     u_div3 : TICK_DIV=3, for the divider/freeze scenario
//     u_sat  : 3 digits, so all-nines saturation is reachable quickly
//   A behavioural model keeps each instance's score as a plain integer and
//   converts to BCD; every driven cycle pushes the expected outputs of all
//   three instances to exp_q, which is popped and compared one cycle later.
//   Each scenario task also checks a few absolute values.
// -----------------------------------------------------------------------------
module tb_score_keeper;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  // step encoding {rst, start, over, frozen, tick}
  localparam logic [4:0] IDLE     = 5'b00000;
  localparam logic [4:0] TICK     = 5'b00001;
  localparam logic [4:0] FRZ_TICK = 5'b00011;
  localparam logic [4:0] OVER     = 5'b00100;
  localparam logic [4:0] START    = 5'b01000;
  localparam logic [4:0] RST      = 5'b10000;

  localparam int W = 135;

  logic clk = 1'b0;
  logic rst, game_start, game_over, game_frozen, game_tick;

  logic [19:0] score_m, high_m, score_d, high_d;
  logic [11:0] score_s, high_s;
  logic [2:0]  level_m, level_d, level_s;
  logic        ms_m, nh_m, ms_d, nh_d, ms_s, nh_s;

  logic [44:0] obs_main, obs_div, obs_sat;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got, exp;
  logic [4:0]   stim_q[$];

  int n_vec = 0;
  int n_err = 0;

  // model state per instance
  int m_cnt[3], m_div[3], m_lvl[3], m_hi[3];
  bit m_ms[3], m_nh[3];
  int m_td[3]  = '{1, 3, 1};
  int m_max[3] = '{99999, 99999, 999};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  score_keeper u_main (
    .clk(clk), .rst(rst), .game_start(game_start), .game_over(game_over),
    .game_frozen(game_frozen), .game_tick(game_tick),
    .score(score_m), .high_score(high_m), .level(level_m),
    .milestone(ms_m), .new_high(nh_m)
  );

  score_keeper #(.NUM_DIGITS(5), .TICK_DIV(3), .LEVEL_W(3)) u_div3 (
    .clk(clk), .rst(rst), .game_start(game_start), .game_over(game_over),
    .game_frozen(game_frozen), .game_tick(game_tick),
    .score(score_d), .high_score(high_d), .level(level_d),
    .milestone(ms_d), .new_high(nh_d)
  );

  score_keeper #(.NUM_DIGITS(3), .TICK_DIV(1), .LEVEL_W(3)) u_sat (
    .clk(clk), .rst(rst), .game_start(game_start), .game_over(game_over),
    .game_frozen(game_frozen), .game_tick(game_tick),
    .score(score_s), .high_score(high_s), .level(level_s),
    .milestone(ms_s), .new_high(nh_s)
  );

  assign obs_main = {score_m, high_m, level_m, ms_m, nh_m};
  assign obs_div  = {score_d, high_d, level_d, ms_d, nh_d};
  assign obs_sat  = {8'h00, score_s, 8'h00, high_s, level_s, ms_s, nh_s};

  // ---------------- model ----------------
  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [44:0] pack(input int i);
    logic [31:0] s, h;
    s = to_bcd(m_cnt[i]);
    h = to_bcd(m_hi[i]);
    return {s[19:0], h[19:0], 3'(m_lvl[i]), m_ms[i], m_nh[i]};
  endfunction

  // Drive one cycle of stimulus, advance the model, push expectations,
  // then step to just after the clock edge.
  task automatic drive(input logic [4:0] s);
    rst         = s[4];
    game_start  = s[3];
    game_over   = s[2];
    game_frozen = s[1];
    game_tick   = s[0];
    for (int i = 0; i < 3; i++) begin
      bit qual;
      bit upd;
      qual = s[0] && !s[1] && !s[3];
      if (s[4]) begin
        m_cnt[i] = 0; m_div[i] = 0; m_lvl[i] = 0; m_hi[i] = 0;
        m_ms[i] = 1'b0; m_nh[i] = 1'b0;
      end else begin
        upd = HS_EN && s[2] && (m_cnt[i] > m_hi[i]);
        if (upd) m_hi[i] = m_cnt[i];
        m_nh[i] = upd && !m_nh[i];
        m_ms[i] = 1'b0;
        if (s[3]) begin
          m_cnt[i] = 0; m_lvl[i] = 0; m_div[i] = 0;
        end else if (qual) begin
          if (m_div[i] == m_td[i] - 1) begin
            m_div[i] = 0;
            if (m_cnt[i] < m_max[i]) begin
              m_cnt[i]++;
              if (m_cnt[i] % 100 == 0) begin
                m_ms[i] = 1'b1;
                if (m_lvl[i] < 7) m_lvl[i]++;
              end
            end
          end else begin
            m_div[i]++;
          end
        end
      end
    end
    exp_q.push_back({pack(0), pack(1), pack(2)});
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    repeat (2) stim_q.push_back(RST);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      got = {obs_main, obs_div, obs_sat}; exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL reset_step got=%h exp=%h", got, exp); end
    end
    n_vec++;
    if (obs_main !== 45'd0) begin n_err++; $display("FAIL reset_zero got=%h exp=0", obs_main); end
  endtask

  task automatic test_count;
    stim_q.push_back(START);
    repeat (3) stim_q.push_back(TICK);
    stim_q.push_back(IDLE);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      got = {obs_main, obs_div, obs_sat}; exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL count_step got=%h exp=%h", got, exp); end
    end
    n_vec++;
    if (score_m !== 20'h00003 || level_m !== 3'd0) begin
      n_err++; $display("FAIL count_score got=%h/%0d exp=00003/0", score_m, level_m);
    end
  endtask

  task automatic test_milestone;
    stim_q.push_back(START);
    repeat (100) stim_q.push_back(TICK);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      got = {obs_main, obs_div, obs_sat}; exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL milestone_step got=%h exp=%h", got, exp); end
    end
    n_vec++;
    if (score_m !== 20'h00100 || ms_m !== 1'b1 || level_m !== 3'd1) begin
      n_err++; $display("FAIL milestone_hit got=%h/%b/%0d exp=00100/1/1", score_m, ms_m, level_m);
    end
    stim_q.push_back(IDLE);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      got = {obs_main, obs_div, obs_sat}; exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL milestone_step got=%h exp=%h", got, exp); end
    end
    n_vec++;
    if (ms_m !== 1'b0 || level_m !== 3'd1) begin
      n_err++; $display("FAIL milestone_pulse got=%b/%0d exp=0/1", ms_m, level_m);
    end
  endtask

  task automatic test_high_score;
    stim_q.push_back(RST);
    stim_q.push_back(START);
    repeat (42) stim_q.push_back(TICK);
    stim_q.push_back(OVER);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      got = {obs_main, obs_div, obs_sat}; exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL high_step got=%h exp=%h", got, exp); end
    end
    n_vec++;
    if (high_m !== (HS_EN ? 20'h00042 : 20'h0) || nh_m !== HS_EN) begin
      n_err++; $display("FAIL high_load got=%h/%b exp=%h/%b", high_m, nh_m,
                        HS_EN ? 20'h00042 : 20'h0, HS_EN);
    end
    stim_q.push_back(START);
    repeat (17) stim_q.push_back(TICK);
    stim_q.push_back(OVER);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      got = {obs_main, obs_div, obs_sat}; exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL high_step got=%h exp=%h", got, exp); end
    end
    n_vec++;
    if (high_m !== (HS_EN ? 20'h00042 : 20'h0) || nh_m !== 1'b0 || score_m !== 20'h00017) begin
      n_err++; $display("FAIL high_keep got=%h/%b/%h exp=%h/0/00017", high_m, nh_m, score_m,
                        HS_EN ? 20'h00042 : 20'h0);
    end
  endtask

  task automatic test_over_start;
    stim_q.push_back(START);
    repeat (50) stim_q.push_back(TICK);
    stim_q.push_back(OVER | START);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      got = {obs_main, obs_div, obs_sat}; exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL over_start_step got=%h exp=%h", got, exp); end
    end
    n_vec++;
    if (high_m !== (HS_EN ? 20'h00050 : 20'h0) || score_m !== 20'h0) begin
      n_err++; $display("FAIL over_start got=%h/%h exp=%h/00000", high_m, score_m,
                        HS_EN ? 20'h00050 : 20'h0);
    end
  endtask

  task automatic test_over_with_tick;
    stim_q.push_back(START);
    repeat (60) stim_q.push_back(TICK);
    stim_q.push_back(OVER | TICK);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      got = {obs_main, obs_div, obs_sat}; exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL over_tick_step got=%h exp=%h", got, exp); end
    end
    n_vec++;
    if (high_m !== (HS_EN ? 20'h00060 : 20'h0) || score_m !== 20'h00061) begin
      n_err++; $display("FAIL over_tick got=%h/%h exp=%h/00061", high_m, score_m,
                        HS_EN ? 20'h00060 : 20'h0);
    end
  endtask

  task automatic test_frozen_div;
    stim_q.push_back(START);
    repeat (3) stim_q.push_back(TICK);
    repeat (2) stim_q.push_back(FRZ_TICK);
    repeat (2) stim_q.push_back(TICK);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      got = {obs_main, obs_div, obs_sat}; exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL frozen_step got=%h exp=%h", got, exp); end
    end
    n_vec++;
    if (score_d !== 20'h00001 || score_m !== 20'h00005) begin
      n_err++; $display("FAIL frozen_score got=%h/%h exp=00001/00005", score_d, score_m);
    end
    // divider sits at 2, so one more qualified tick completes the next point
    stim_q.push_back(TICK);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      got = {obs_main, obs_div, obs_sat}; exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL frozen_step got=%h exp=%h", got, exp); end
    end
    n_vec++;
    if (score_d !== 20'h00002) begin
      n_err++; $display("FAIL frozen_div got=%h exp=00002", score_d);
    end
  endtask

  task automatic test_saturate;
    stim_q.push_back(START);
    repeat (1003) stim_q.push_back(TICK);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      got = {obs_main, obs_div, obs_sat}; exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL saturate_step got=%h exp=%h", got, exp); end
    end
    n_vec++;
    if (score_s !== 12'h999 || level_s !== 3'd7 || ms_s !== 1'b0) begin
      n_err++; $display("FAIL saturate_hold got=%h/%0d/%b exp=999/7/0", score_s, level_s, ms_s);
    end
    n_vec++;
    if (score_m !== 20'h01003 || level_m !== 3'd7) begin
      n_err++; $display("FAIL level_sat got=%h/%0d exp=01003/7", score_m, level_m);
    end
  endtask

  task automatic test_reset_priority;
    stim_q.push_back(START);
    repeat (99) stim_q.push_back(TICK);
    stim_q.push_back(OVER);
    stim_q.push_back(RST | START | OVER | TICK);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      got = {obs_main, obs_div, obs_sat}; exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL rst_prio_step got=%h exp=%h", got, exp); end
    end
    n_vec++;
    if (obs_main !== 45'd0 || obs_sat !== 45'd0) begin
      n_err++; $display("FAIL rst_prio got=%h/%h exp=0/0", obs_main, obs_sat);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 600; k++) begin
      stim_q.push_back({($urandom_range(199) == 0), ($urandom_range(39) == 0),
                        ($urandom_range(29) == 0), ($urandom_range(3) == 0),
                        ($urandom_range(1) == 0)});
    end
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      got = {obs_main, obs_div, obs_sat}; exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL random_step got=%h exp=%h", got, exp); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_count();
    test_milestone();
    test_high_score();
    test_over_start();
    test_over_with_tick();
    test_frozen_div();
    test_saturate();
    test_reset_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
